// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-based up/down counter.
//   - jk_code_t / JK_* : two-bit {J,K} excitation encodings used by every JK cell.
//   - modulus_legal()  : elaboration-time legality test for a modulo-N counter.
//   - JK_MODULUS_CHECK : macro that places an elaboration error in a generate
//                        scope when the modulus does not fit the width.
`ifndef JK_UPDOWN_COUNTER_PKG_SV
`define JK_UPDOWN_COUNTER_PKG_SV

package jk_updown_counter_pkg;

  typedef logic [1:0] jk_code_t;

  // Bit 1 is J, bit 0 is K.
  localparam jk_code_t JK_HOLD   = 2'b00;
  localparam jk_code_t JK_RESET  = 2'b01;
  localparam jk_code_t JK_SET    = 2'b10;
  localparam jk_code_t JK_TOGGLE = 2'b11;

  // A modulo-N counter needs at least two states and all of them must be
  // representable in the chosen width.
  function automatic bit modulus_legal(input int width, input int modulus);
    return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage

`define JK_MODULUS_CHECK(W, M) \
  if (!jk_updown_counter_pkg::modulus_legal(W, M)) begin : g_bad_modulus \
    $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH"); \
  end

`endif

// File: rtl/jk_ff_async.sv
// Single-bit JK storage cell with complementary registered outputs.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low clear (q=0, q_inverse=1)
//   j, k      : excitation inputs (HOLD/RESET/SET/TOGGLE)
//   q         : stored bit
//   q_inverse : registered complement of q
module jk_ff_async
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_inverse
);

  logic q_next;

  always_comb begin
    q_next = q;
    case ({j, k})
      JK_HOLD:   q_next = q;
      JK_RESET:  q_next = 1'b0;
      JK_SET:    q_next = 1'b1;
      JK_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

  // q_inverse is its own flop so both outputs come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= 1'b0;
      q_inverse <= 1'b1;
    end else begin
      q         <= q_next;
      q_inverse <= ~q_next;
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK cells.
//   clk, rst_n    : clock and asynchronous active-low reset
//   en            : count enable
//   up            : 1 = increment, 0 = decrement
//   load          : synchronous parallel load (priority over en)
//   load_val      : value to load; out-of-range values load MODULUS-1
//   count         : registered Q of each bit
//   count_inverse : registered Q_inverse of each bit (always ~count)
//   tc            : combinational terminal count, predicts wrap on next edge
//   wrap          : registered one-cycle pulse on wrap-around
//   load_err      : registered one-cycle pulse on out-of-range load
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_inverse,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  `JK_MODULUS_CHECK(WIDTH, MODULUS)

  // MODULUS may equal 2**WIDTH, so range compares use one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] nxt;
  logic             wrap_d;
  logic             load_err_d;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // Next-state selection: load > en > hold.
  always_comb begin
    nxt        = count;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        nxt = load_val;
      end else begin
        nxt        = MAX_VAL;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if ({1'b0, count} >= MOD_EXT) begin
        // Recovery from a forced illegal state, independent of direction.
        nxt = ZERO;
      end else if (up) begin
        if (count == MAX_VAL) begin
          nxt    = ZERO;
          wrap_d = 1'b1;
        end else begin
          nxt = count + ONE;
        end
      end else begin
        if (count == ZERO) begin
          nxt    = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          nxt = count - ONE;
        end
      end
    end
  end

  // Excitation: only HOLD/SET/RESET are ever produced; a bit that keeps its
  // value is held rather than re-written.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_code_t code;
    assign code = (count[i] == nxt[i]) ? JK_HOLD : (nxt[i] ? JK_SET : JK_RESET);
    assign j_vec[i] = code[1];
    assign k_vec[i] = code[0];

    jk_ff_async u_ff (
      .clk       (clk),
      .rst_n     (rst_n),
      .j         (j_vec[i]),
      .k         (k_vec[i]),
      .q         (count[i]),
      .q_inverse (count_inverse[i])
    );
  end

  assign tc = en & ~load & ((up & (count == MAX_VAL)) | (~up & (count == ZERO)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_inverse;
  logic             tc;
  logic             wrap;
  logic             load_err;

  int errors = 0;
  int checks = 0;

  // Behavioural reference state.
  int mdl_cnt  = 0;
  int mdl_wrap = 0;
  int mdl_err  = 0;

  // tc observed / predicted just before the most recent edge.
  logic obs_tc;
  logic exp_tc;

  jk_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .up            (up),
    .load          (load),
    .load_val      (load_val),
    .count         (count),
    .count_inverse (count_inverse),
    .tc            (tc),
    .wrap          (wrap),
    .load_err      (load_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Complement and no-TOGGLE invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (count_inverse !== ~count) begin
        errors++;
        $display("FAIL complement: count=%h count_inverse=%h expected %h", count, count_inverse, ~count);
      end
      checks++;
      if ((dut.j_vec & dut.k_vec) !== '0) begin
        errors++;
        $display("FAIL no_toggle: j=%b k=%b expected no bit with j=k=1", dut.j_vec, dut.k_vec);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after an edge. Applies inputs, captures tc before the next
  // edge, then advances the reference model from the counting rules.
  task automatic step(input logic e, input logic u, input logic l, input logic [WIDTH-1:0] lv);
    int nxt;
    int w;
    int le;
    en = e; up = u; load = l; load_val = lv;
    #2;
    obs_tc = tc;
    exp_tc = (e && !l && ((u && mdl_cnt == MODULUS-1) || (!u && mdl_cnt == 0)));
    w  = 0;
    le = 0;
    if (l) begin
      if (int'(lv) < MODULUS) nxt = int'(lv);
      else begin nxt = MODULUS - 1; le = 1; end
    end else if (e) begin
      if (u) begin
        nxt = (mdl_cnt + 1) % MODULUS;
        w   = (mdl_cnt == MODULUS - 1);
      end else begin
        nxt = (mdl_cnt + MODULUS - 1) % MODULUS;
        w   = (mdl_cnt == 0);
      end
    end else begin
      nxt = mdl_cnt;
    end
    @(posedge clk);
    #1;
    mdl_cnt  = nxt;
    mdl_wrap = w;
    mdl_err  = le;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    en = 0; up = 1; load = 0; load_val = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (count !== 4'd0 || count_inverse !== 4'hF || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d inv=%h wrap=%b err=%b expected 0 f 0 0", count, count_inverse, wrap, load_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_cnt = 0; mdl_wrap = 0; mdl_err = 0;
  endtask

  task automatic test_up_wrap();
    step(1'b0, 1'b1, 1'b1, 4'd0);   // start from 0
    for (int i = 0; i < MODULUS; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0);
      checks++;
      if (obs_tc !== exp_tc) begin
        errors++;
        $display("FAIL up_tc: step %0d tc=%b expected %b", i, obs_tc, exp_tc);
      end
      checks++;
      if (count !== WIDTH'(mdl_cnt) || wrap !== 1'(mdl_wrap)) begin
        errors++;
        $display("FAIL up_count: step %0d count=%0d wrap=%b expected %0d %0d", i, count, wrap, mdl_cnt, mdl_wrap);
      end
    end
    checks++;
    if (count !== 4'd0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_end: count=%0d wrap=%b expected 0 1", count, wrap);
    end
    step(1'b1, 1'b1, 1'b0, 4'd0);
    checks++;
    if (count !== 4'd1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap_pulse: count=%0d wrap=%b expected 1 0", count, wrap);
    end
  endtask

  task automatic test_down_wrap();
    logic [WIDTH-1:0] exp_seq [3];
    logic             exp_w   [3];
    exp_seq[0] = 4'd9; exp_seq[1] = 4'd8; exp_seq[2] = 4'd7;
    exp_w[0] = 1'b1;   exp_w[1] = 1'b0;   exp_w[2] = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      checks++;
      if (count !== exp_seq[i] || wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL down_wrap: step %0d count=%0d wrap=%b expected %0d %b", i, count, wrap, exp_seq[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_load();
    step(1'b1, 1'b1, 1'b1, 4'd6);
    checks++;
    if (count !== 4'd6 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_ok: count=%0d wrap=%b err=%b expected 6 0 0", count, wrap, load_err);
    end
    step(1'b1, 1'b0, 1'b1, 4'd12);
    checks++;
    if (count !== 4'd9 || load_err !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_range: count=%0d err=%b wrap=%b expected 9 1 0", count, load_err, wrap);
    end
    step(1'b1, 1'b1, 1'b1, 4'd15);
    checks++;
    if (count !== 4'd9 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_err_b2b: count=%0d err=%b expected 9 1", count, load_err);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (load_err !== 1'b0 || count !== 4'd9) begin
      errors++;
      $display("FAIL load_err_clear: count=%0d err=%b expected 9 0", count, load_err);
    end
  endtask

  task automatic test_hold_dir();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 4'd6; exp_seq[1] = 4'd5; exp_seq[2] = 4'd6; exp_seq[3] = 4'd5;
    step(1'b0, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i % 2), 1'b0, 4'd0);
      checks++;
      if (count !== 4'd5 || obs_tc !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold: step %0d count=%0d tc=%b wrap=%b expected 5 0 0", i, count, obs_tc, wrap);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'(i % 2 == 0), 1'b0, 4'd0);
      checks++;
      if (count !== exp_seq[i]) begin
        errors++;
        $display("FAIL dir_flip: step %0d count=%0d expected %0d", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    // With MODULUS-1 -> 0 up then 0 -> MODULUS-1 down, wrap stays high twice.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    checks++;
    if (count !== 4'd0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap_1: count=%0d wrap=%b expected 0 1", count, wrap);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (count !== 4'd9 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap_2: count=%0d wrap=%b expected 9 1", count, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      checks++;
      if (obs_tc !== exp_tc) begin
        errors++;
        $display("FAIL rand_tc: iter %0d tc=%b expected %b", i, obs_tc, exp_tc);
      end
      checks++;
      if (count !== WIDTH'(mdl_cnt) || wrap !== 1'(mdl_wrap) || load_err !== 1'(mdl_err)) begin
        errors++;
        $display("FAIL rand_state: iter %0d count=%0d wrap=%b err=%b expected %0d %0d %0d",
                 i, count, wrap, load_err, mdl_cnt, mdl_wrap, mdl_err);
      end
    end
  endtask

  task automatic test_reset_midcount();
    step(1'b0, 1'b1, 1'b1, 4'd7);
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL pre_reset: count=%0d expected 7", count);
    end
    // Pending load and enable must be overridden by reset.
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd3;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || count_inverse !== 4'hF || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d inv=%h wrap=%b err=%b expected 0 f 0 0", count, count_inverse, wrap, load_err);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: count=%0d expected 0", count);
    end
    rst_n = 1'b1;
    mdl_cnt = 0; mdl_wrap = 0; mdl_err = 0;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (count !== 4'd9 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_edge: count=%0d wrap=%b expected 9 1", count, wrap);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0; en = 0; up = 1; load = 0; load_val = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
    test_back_to_back_wrap();
    test_random();
    test_reset_midcount();
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
Synchronous modulo-N up/down counter built from a bank of JK flip-flops.
- Excitation logic computes per-bit J/K from current state and requested next state.
- Each bit drives a JK storage cell with complementary outputs, the same Q/Q_inverse convention as the existing flip-flop blocks.
- Produces the count vector, its complement, a terminal-count flag and a wrap pulse for the next stage downstream.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered Q of each bit).
- count_inverse  output  WIDTH  registered Q_inverse of each bit; always equals ~count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse on wrap-around.
- load_err  output  1  registered one-cycle pulse on out-of-range load.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (rst_n=0, no clock needed): count=0, count_inverse all ones, wrap=0, load_err=0.
  - Reset mid-count overrides any in-flight load or enable.
  - First active edge after rst_n rises acts normally.
- Priority on each rising clk edge: load > en > hold.
- Load:
  - If load_val < MODULUS, next = load_val.
  - Else next = MODULUS-1 and load_err=1 for that cycle.
  - wrap=0 on a load cycle. Direction is ignored.
- Count, en=1 and load=0:
  - up=1: next = count+1, except count==MODULUS-1 gives next=0 and wrap=1.
  - up=0: next = count-1, except count==0 gives next=MODULUS-1 and wrap=1.
- Hold, en=0 and load=0: next=count; wrap=0, load_err=0.
- wrap and load_err are registered on the same edge as count. Each is high for exactly one cycle per event; back-to-back events keep it high on consecutive cycles.
- tc = en & ~load & ((up & count==MODULUS-1) | (~up & count==0)). It is purely combinational and predicts wrap on the next edge.
- Excitation per bit i, using the shared JK encodings:
  - q=0, next=0: HOLD.
  - q=0, next=1: SET.
  - q=1, next=0: RESET.
  - q=1, next=1: HOLD.
  - TOGGLE is never generated. Storage cells still implement it for reuse.
- Latency: one clock from input sample to count/wrap/load_err update.
- No illegal count state is reachable from reset. If count is forced >= MODULUS, the next enabled edge in either direction loads 0.
- Direction changes take effect on the same edge; there is no pipeline.

Decomposition:
- Shared package/header: JK encoding constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11, plus the MODULUS legality check macro.
- Sub-module jk_ff_async:
  - Single-bit JK cell with ports clk, rst_n, j, k, q, q_inverse.
  - Async clear to q=0, q_inverse=1; HOLD/RESET/SET/TOGGLE on posedge clk.
  - Instantiated WIDTH times via generate.
- Top level holds next-state logic, excitation logic, and the wrap/load_err registers.

Test Plan:
- Reset: assert rst_n=0 mid-count at count=7 between edges -> count=0, count_inverse=4'b1111, wrap=0 immediately without a clock edge.
- Up wrap, MODULUS=10: en=1, up=1 from 0 for 10 edges -> count 1..9 then 0. tc=1 only while count=9. wrap=1 exactly one cycle after the 9->0 edge.
- Down wrap: en=1, up=0 from 0 -> next edge count=9, wrap=1. Following edges give 8,7 with wrap=0.
- Load priority and range: load=1, en=1, load_val=4'd6 -> count=6, wrap=0. Then load_val=4'd12 -> count=9, load_err=1 for one cycle.
- Hold and direction flip: en=0 for 3 edges at count=5 -> count stays 5, tc=0. Then en=1 alternating up=1/0 each edge -> 6,5,6,5.
- Complement invariant: across all cycles of the above, count_inverse == ~count and J/K never equals TOGGLE (checked by assertion).
